// File: rtl/nn_slice_sequencer.sv
// -----------------------------------------------------------------------------
// nn_slice_sequencer
//
// Steps a dot-product unit through the sub-word slices of a mixed-precision
// operand. Each slice is reused for a programmable number of dotp issues (the
// skip count). When the last slice has been used, the sequencer stops ID from
// issuing and requests an operand-buffer refill. Issue resumes when the refill
// data has returned.
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   cfg_valid_i      configuration strobe
//   cfg_ready_o      configuration accepted when high together with cfg_valid_i
//   cfg_fmt_i        format: 1 -> 2 slices, 2 -> 4 slices, 3 -> 8 slices,
//                    any other code -> no mixed op (return to IDLE)
//   cfg_skip_i       dotp issues per slice (0 is treated as 1)
//   dotp_fire_i      one dotp/sdotp/MAC&LOAD accepted by EX this cycle
//   flush_i          restart the slice sequence (RUN only)
//   slice_o          current sub-word slice index
//   slice_adv_o      one-cycle pulse in the cycle slice_o takes a new value
//   refill_req_o     operand-buffer refill request, held until granted
//   refill_gnt_i     refill request accepted
//   refill_rvalid_i  refill data returned
//   stall_o          ID must not issue dotp
//   busy_o           sequencer is not IDLE
// -----------------------------------------------------------------------------
module nn_slice_sequencer #(
  parameter int unsigned SKIP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [2:0]        cfg_fmt_i,
  input  logic [SKIP_W-1:0] cfg_skip_i,
  input  logic              dotp_fire_i,
  input  logic              flush_i,
  output logic [2:0]        slice_o,
  output logic              slice_adv_o,
  output logic              refill_req_o,
  input  logic              refill_gnt_i,
  input  logic              refill_rvalid_i,
  output logic              stall_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e            state_q,    state_d;
  logic [2:0]        fmt_q,      fmt_d;
  logic [SKIP_W-1:0] skip_q,     skip_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [2:0]        slice_q,    slice_d;
  logic              slice_adv_q, slice_adv_d;

  logic              cfg_accept;
  logic              cfg_fmt_ok;
  logic [SKIP_W-1:0] skip_last;
  logic [2:0]        slice_last;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  // Configuration is only taken while no refill is outstanding.
  assign cfg_ready_o = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign cfg_accept  = cfg_valid_i && cfg_ready_o;
  assign cfg_fmt_ok  = (cfg_fmt_i == 3'd1) || (cfg_fmt_i == 3'd2) || (cfg_fmt_i == 3'd3);

  // Last value of the skip counter before the slice advances. A latched skip
  // of zero behaves like one, so both give a last count of zero.
  assign skip_last = (skip_q == '0) ? '0 : (skip_q - SKIP_W'(1));

  // Highest slice index for the latched format (NSL - 1).
  always_comb begin
    case (fmt_q)
      3'd1:    slice_last = 3'd1;
      3'd2:    slice_last = 3'd3;
      default: slice_last = 3'd7;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    skip_d      = skip_q;
    skip_cnt_d  = skip_cnt_q;
    slice_d     = slice_q;
    slice_adv_d = 1'b0;

    if (cfg_accept) begin
      // A new configuration wins over flush and dotp in the same cycle and
      // always restarts the sequence without an advance pulse.
      skip_cnt_d = '0;
      slice_d    = 3'd0;
      if (cfg_fmt_ok) begin
        fmt_d   = cfg_fmt_i;
        skip_d  = cfg_skip_i;
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_i) begin
            skip_cnt_d = '0;
            slice_d    = 3'd0;
          end else if (dotp_fire_i) begin
            if (skip_cnt_q < skip_last) begin
              skip_cnt_d = skip_cnt_q + SKIP_W'(1);
            end else begin
              skip_cnt_d  = '0;
              slice_adv_d = 1'b1;
              if (slice_q == slice_last) begin
                // All slices consumed: wrap and fetch fresh operands.
                slice_d = 3'd0;
                state_d = ST_REQ;
              end else begin
                slice_d = slice_q + 3'd1;
              end
            end
          end
        end

        ST_REQ: begin
          if (refill_gnt_i) begin
            state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (refill_rvalid_i) begin
            state_d = ST_RUN;
          end
        end

        default: begin
          // IDLE: only a configuration leaves this state.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fmt_q       <= 3'd0;
      skip_q      <= SKIP_W'(1);
      skip_cnt_q  <= '0;
      slice_q     <= 3'd0;
      slice_adv_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      skip_q      <= skip_d;
      skip_cnt_q  <= skip_cnt_d;
      slice_q     <= slice_d;
      slice_adv_q <= slice_adv_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registered or decoded from the registered state only
  // ---------------------------------------------------------------------------
  assign slice_o      = slice_q;
  assign slice_adv_o  = slice_adv_q;
  assign refill_req_o = (state_q == ST_REQ);
  assign stall_o      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nn_slice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_slice_sequencer
//
// Self-checking bench for nn_slice_sequencer. A table of per-cycle stimulus
// records carries the expected architectural state after each edge; the bench
// turns that state into the expected output bundle, pushes it on a scoreboard
// queue when the stimulus is driven and pops/compares it once the DUT has
// clocked. Reset behaviour is exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_nn_slice_sequencer;

  localparam int unsigned SKIP_W = 8;

  typedef enum logic [1:0] {S_I, S_R, S_Q, S_W} exp_st_e;

  typedef struct {
    string             name;
    logic              cv;
    logic [2:0]        fmt;
    logic [SKIP_W-1:0] skip;
    logic              fire;
    logic              flush;
    logic              gnt;
    logic              rv;
    exp_st_e           st;
    logic [2:0]        slice;
    logic              adv;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] out;
  } sb_t;

  logic              clk;
  logic              rst_n;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [2:0]        cfg_fmt_i;
  logic [SKIP_W-1:0] cfg_skip_i;
  logic              dotp_fire_i;
  logic              flush_i;
  logic [2:0]        slice_o;
  logic              slice_adv_o;
  logic              refill_req_o;
  logic              refill_gnt_i;
  logic              refill_rvalid_i;
  logic              stall_o;
  logic              busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];
  sb_t  sb_q[$];

  nn_slice_sequencer #(.SKIP_W(SKIP_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_fmt_i       (cfg_fmt_i),
    .cfg_skip_i      (cfg_skip_i),
    .dotp_fire_i     (dotp_fire_i),
    .flush_i         (flush_i),
    .slice_o         (slice_o),
    .slice_adv_o     (slice_adv_o),
    .refill_req_o    (refill_req_o),
    .refill_gnt_i    (refill_gnt_i),
    .refill_rvalid_i (refill_rvalid_i),
    .stall_o         (stall_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output bundle: {cfg_ready, slice[2:0], slice_adv, refill_req, stall, busy}
  function automatic logic [7:0] exp_out(exp_st_e st, logic [2:0] slice, logic adv);
    logic ready, req, stall, busy;
    ready = (st == S_I) || (st == S_R);
    req   = (st == S_Q);
    stall = (st == S_Q) || (st == S_W);
    busy  = (st != S_I);
    return {ready, slice, adv, req, stall, busy};
  endfunction

  function automatic logic [7:0] dut_out();
    return {cfg_ready_o, slice_o, slice_adv_o, refill_req_o, stall_o, busy_o};
  endfunction

  function automatic vec_t mk(string name, logic cv, logic [2:0] fmt,
                              logic [SKIP_W-1:0] skip, logic fire, logic flush,
                              logic gnt, logic rv, exp_st_e st,
                              logic [2:0] slice, logic adv);
    vec_t v;
    v.name = name; v.cv = cv; v.fmt = fmt; v.skip = skip; v.fire = fire;
    v.flush = flush; v.gnt = gnt; v.rv = rv; v.st = st; v.slice = slice;
    v.adv = adv;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rdy,slice,adv,req,stall,busy}=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cfg_valid_i     = 1'b0;
    cfg_fmt_i       = 3'd0;
    cfg_skip_i      = '0;
    dotp_fire_i     = 1'b0;
    flush_i         = 1'b0;
    refill_gnt_i    = 1'b0;
    refill_rvalid_i = 1'b0;
  endtask

  // Drive one cycle of stimulus (called just after a rising edge), let the
  // DUT clock it, then compare the post-edge outputs against the scoreboard.
  task automatic apply(input vec_t v);
    sb_t e;
    cfg_valid_i     = v.cv;
    cfg_fmt_i       = v.fmt;
    cfg_skip_i      = v.skip;
    dotp_fire_i     = v.fire;
    flush_i         = v.flush;
    refill_gnt_i    = v.gnt;
    refill_rvalid_i = v.rv;
    e.name = v.name;
    e.out  = exp_out(v.st, v.slice, v.adv);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty at sample", v.name);
    end else begin
      e = sb_q.pop_front();
      check(e.name, dut_out(), e.out);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // fmt=1 skip=3: slice 0 for three fires, 1 for three, then wrap to REQ.
    tbl.push_back(mk("a_cfg_f1_s3", 1, 3'd1, 8'd3, 0, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("a_fire1",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("a_fire2",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("a_fire3",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    tbl.push_back(mk("a_fire4",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 0));
    tbl.push_back(mk("a_fire5",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 0));
    tbl.push_back(mk("a_fire6",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_Q, 3'd0, 1));
    // REQ held while gnt is late by 4 cycles; fires, rvalid and cfg ignored.
    tbl.push_back(mk("b_req_rv",    0, 3'd0, 8'd0, 1, 0, 0, 1, S_Q, 3'd0, 0));
    tbl.push_back(mk("b_req_cfg",   1, 3'd2, 8'd2, 1, 0, 0, 0, S_Q, 3'd0, 0));
    tbl.push_back(mk("b_req3",      0, 3'd0, 8'd0, 1, 1, 0, 0, S_Q, 3'd0, 0));
    tbl.push_back(mk("b_req4",      0, 3'd0, 8'd0, 1, 0, 0, 0, S_Q, 3'd0, 0));
    tbl.push_back(mk("b_gnt",       0, 3'd0, 8'd0, 1, 0, 1, 0, S_W, 3'd0, 0));
    tbl.push_back(mk("b_wait_gnt",  0, 3'd0, 8'd0, 1, 0, 1, 0, S_W, 3'd0, 0));
    tbl.push_back(mk("b_rvalid",    0, 3'd0, 8'd0, 1, 0, 0, 1, S_R, 3'd0, 0));
    // Counter must have stayed at 0 through the stall.
    tbl.push_back(mk("b_run_f1",    0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("b_run_f2",    0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("b_run_f3",    0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    // cfg + flush + fire together: new config wins, counters cleared.
    tbl.push_back(mk("c_fire",      0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 0));
    tbl.push_back(mk("c_cfg_fl_fi", 1, 3'd2, 8'd2, 1, 1, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("c_f1",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("c_f2",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    tbl.push_back(mk("c_f3",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 0));
    tbl.push_back(mk("c_flush",     0, 3'd0, 8'd0, 1, 1, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("c_f4",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd0, 0));
    tbl.push_back(mk("c_f5",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    tbl.push_back(mk("c_f6",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 0));
    tbl.push_back(mk("c_f7",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd2, 1));
    tbl.push_back(mk("c_f8",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd2, 0));
    tbl.push_back(mk("c_f9",        0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd3, 1));
    tbl.push_back(mk("c_f10",       0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd3, 0));
    tbl.push_back(mk("c_wrap4",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_Q, 3'd0, 1));
    tbl.push_back(mk("c_gnt",       0, 3'd0, 8'd0, 0, 0, 1, 0, S_W, 3'd0, 0));
    tbl.push_back(mk("c_rvalid",    0, 3'd0, 8'd0, 0, 0, 0, 1, S_R, 3'd0, 0));
    // fmt=3 skip=0 (acts as 1): every fire advances through 8 slices.
    tbl.push_back(mk("d_cfg_f3_s0", 1, 3'd3, 8'd0, 0, 0, 0, 0, S_R, 3'd0, 0));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk($sformatf("d_fire%0d", i), 0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'(i), 1));
    tbl.push_back(mk("d_wrap8",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_Q, 3'd0, 1));
    tbl.push_back(mk("d_gnt",       0, 3'd0, 8'd0, 0, 0, 1, 0, S_W, 3'd0, 0));
    tbl.push_back(mk("d_rvalid",    0, 3'd0, 8'd0, 0, 0, 0, 1, S_R, 3'd0, 0));
    tbl.push_back(mk("d_fire_run",  0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    // Invalid formats drop to IDLE and clear the slice; IDLE ignores the rest.
    tbl.push_back(mk("e_cfg_f5",    1, 3'd5, 8'd3, 1, 1, 0, 0, S_I, 3'd0, 0));
    tbl.push_back(mk("e_idle_fire", 0, 3'd0, 8'd0, 1, 0, 0, 0, S_I, 3'd0, 0));
    tbl.push_back(mk("e_idle_misc", 0, 3'd0, 8'd0, 1, 1, 1, 1, S_I, 3'd0, 0));
    tbl.push_back(mk("e_cfg_f0",    1, 3'd0, 8'd4, 1, 0, 0, 0, S_I, 3'd0, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), exp_out(S_I, 3'd0, 1'b0));
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset during WAIT; later rvalid must be ignored.
    apply(mk("f_cfg_f1_s1", 1, 3'd1, 8'd1, 0, 0, 0, 0, S_R, 3'd0, 0));
    apply(mk("f_fire1",     0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));
    apply(mk("f_wrap",      0, 3'd0, 8'd0, 1, 0, 0, 0, S_Q, 3'd0, 1));
    apply(mk("f_gnt",       0, 3'd0, 8'd0, 0, 0, 1, 0, S_W, 3'd0, 0));
    drive_idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("f_async_rst", dut_out(), exp_out(S_I, 3'd0, 1'b0));
    refill_rvalid_i = 1'b1;
    @(posedge clk);
    #1;
    check("f_rst_held", dut_out(), exp_out(S_I, 3'd0, 1'b0));
    rst_n = 1'b1;
    apply(mk("f_rv_after",  0, 3'd0, 8'd0, 1, 0, 0, 1, S_I, 3'd0, 0));
    apply(mk("f_cfg_again", 1, 3'd2, 8'd1, 0, 0, 0, 0, S_R, 3'd0, 0));
    apply(mk("f_fire_again",0, 3'd0, 8'd0, 1, 0, 0, 0, S_R, 3'd1, 1));

    drive_idle();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
